// File: rtl/hplvds_rx_lane_ctrl.sv
// ============================================================================
//  Module   : hplvds_rx_lane_ctrl
//  Brief    : Power-up sequencer, data/EI synchroniser and EI hysteresis
//             filter for a bank of HPLVDS receiver pad cells.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module hplvds_rx_lane_ctrl #(
    parameter int LANES      = 4,
    parameter int SETTLE_CYC = 64,
    parameter int EI_FILT    = 8
) (
    input  logic             CLK_I,
    input  logic             RSTN_I,
    input  logic             EN_I,
    input  logic [LANES-1:0] LANE_MASK_I,
    input  logic [LANES-1:0] POL_I,
    input  logic             EI_DET_EN_I,
    input  logic [3:0]       RTERM_TRIM_I,
    input  logic [LANES-1:0] DI_I,
    input  logic [LANES-1:0] EI_DETECT_I,
    output logic [LANES-1:0] RTERM_EN_O,
    output logic [LANES-1:0] RX_VCM_EN_O,
    output logic [LANES-1:0] RX_EN_O,
    output logic [LANES-1:0] RX_POL_O,
    output logic [LANES-1:0] EI_DETECT_EN_O,
    output logic [3:0]       RTERM_TRIM_O,
    output logic [LANES-1:0] DATA_O,
    output logic [LANES-1:0] EI_O,
    output logic             LINK_IDLE_O,
    output logic             READY_O,
    output logic [2:0]       STATE_O
);

    localparam int CW = $clog2(SETTLE_CYC + 1);
    localparam int FW = $clog2(EI_FILT + 1);

    localparam logic [2:0] ST_OFF   = 3'd0;
    localparam logic [2:0] ST_TERM  = 3'd1;
    localparam logic [2:0] ST_BIAS  = 3'd2;
    localparam logic [2:0] ST_RXON  = 3'd3;
    localparam logic [2:0] ST_READY = 3'd4;

    logic             en_q;
    logic [2:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             w_expire;

    logic [LANES-1:0] rterm_q, vcm_q, rx_en_q, pol_q, ei_en_q;
    logic [LANES-1:0] rterm_d, vcm_d, rx_en_d, ei_en_d;
    logic [3:0]       trim_q;
    logic             ready_q, ready_d, link_q;
    logic [LANES-1:0] di_s1_q, data_q;
    logic [LANES-1:0] ei_s1_q, ei_s2_q;
    logic [LANES-1:0] ei_q, ei_d;

    assign w_expire = (cnt_q == CW'(SETTLE_CYC - 1));

    // Loss of the enable wins over a coincident settle expiry.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        if (!en_q) begin
            state_d = ST_OFF;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_OFF: begin
                    state_d = ST_TERM;
                    cnt_d   = '0;
                end
                ST_TERM: if (w_expire) begin
                    state_d = ST_BIAS;
                    cnt_d   = '0;
                end
                ST_BIAS: if (w_expire) begin
                    state_d = ST_RXON;
                    cnt_d   = '0;
                end
                ST_RXON: if (w_expire) begin
                    state_d = ST_READY;
                    cnt_d   = '0;
                end
                ST_READY: cnt_d = '0;
                default: begin
                    state_d = ST_OFF;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    assign rterm_d = {LANES{state_d != ST_OFF}} & LANE_MASK_I;
    assign vcm_d   = {LANES{state_d >= ST_BIAS}} & LANE_MASK_I;
    assign rx_en_d = {LANES{state_d >= ST_RXON}} & LANE_MASK_I;
    assign ready_d = (state_d == ST_READY);
    assign ei_en_d = {LANES{ready_d & EI_DET_EN_I}} & LANE_MASK_I;

    // Per-lane EI hysteresis: count consecutive samples disagreeing with EI_O.
    for (genvar i = 0; i < LANES; i++) begin : g_ei
        logic [FW-1:0] fcnt_q, fcnt_d;

        always_comb begin
            fcnt_d  = '0;
            ei_d[i] = 1'b0;
            if (ei_en_d[i]) begin
                ei_d[i] = ei_q[i];
                if (ei_s2_q[i] != ei_q[i]) begin
                    if (fcnt_q == FW'(EI_FILT - 1)) begin
                        ei_d[i] = ~ei_q[i];
                    end else begin
                        fcnt_d = fcnt_q + 1'b1;
                    end
                end
            end
        end

        always_ff @(posedge CLK_I or negedge RSTN_I) begin
            if (!RSTN_I) begin
                fcnt_q  <= '0;
                ei_q[i] <= 1'b0;
            end else begin
                fcnt_q  <= fcnt_d;
                ei_q[i] <= ei_d[i];
            end
        end
    end

    always_ff @(posedge CLK_I or negedge RSTN_I) begin
        if (!RSTN_I) begin
            en_q    <= 1'b0;
            state_q <= ST_OFF;
            cnt_q   <= '0;
            rterm_q <= '0;
            vcm_q   <= '0;
            rx_en_q <= '0;
            ei_en_q <= '0;
            pol_q   <= '0;
            trim_q  <= '0;
            ready_q <= 1'b0;
            link_q  <= 1'b0;
            di_s1_q <= '0;
            data_q  <= '0;
            ei_s1_q <= '0;
            ei_s2_q <= '0;
        end else begin
            en_q    <= EN_I;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rterm_q <= rterm_d;
            vcm_q   <= vcm_d;
            rx_en_q <= rx_en_d;
            ei_en_q <= ei_en_d;
            pol_q   <= POL_I;
            ready_q <= ready_d;
            // Trim may only move while termination is off.
            if (state_q == ST_OFF) begin
                trim_q <= RTERM_TRIM_I;
            end
            link_q  <= ready_d & (|LANE_MASK_I) & (&(ei_d | ~LANE_MASK_I));
            di_s1_q <= DI_I;
            data_q  <= di_s1_q & rx_en_d;
            ei_s1_q <= EI_DETECT_I;
            ei_s2_q <= ei_s1_q;
        end
    end

    assign RTERM_EN_O     = rterm_q;
    assign RX_VCM_EN_O    = vcm_q;
    assign RX_EN_O        = rx_en_q;
    assign RX_POL_O       = pol_q;
    assign EI_DETECT_EN_O = ei_en_q;
    assign RTERM_TRIM_O   = trim_q;
    assign DATA_O         = data_q;
    assign EI_O           = ei_q;
    assign LINK_IDLE_O    = link_q;
    assign READY_O        = ready_q;
    assign STATE_O        = state_q;

endmodule

`default_nettype wire

// File: tb/tb_hplvds_rx_lane_ctrl.sv
// ============================================================================
//  Module   : tb_hplvds_rx_lane_ctrl
//  Brief    : Directed self-checking bench for hplvds_rx_lane_ctrl.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_hplvds_rx_lane_ctrl;

    logic       CLK_I = 1'b0;
    logic       RSTN_I;
    logic       EN_I;
    logic [3:0] LANE_MASK_I;
    logic [3:0] POL_I;
    logic       EI_DET_EN_I;
    logic [3:0] RTERM_TRIM_I;
    logic [3:0] DI_I;
    logic [3:0] EI_DETECT_I;
    logic [3:0] RTERM_EN_O, RX_VCM_EN_O, RX_EN_O, RX_POL_O, EI_DETECT_EN_O;
    logic [3:0] RTERM_TRIM_O, DATA_O, EI_O;
    logic       LINK_IDLE_O, READY_O;
    logic [2:0] STATE_O;

    int vecs = 0;
    int errs = 0;

    hplvds_rx_lane_ctrl #(
        .LANES      (4),
        .SETTLE_CYC (4),
        .EI_FILT    (8)
    ) dut (
        .CLK_I          (CLK_I),
        .RSTN_I         (RSTN_I),
        .EN_I           (EN_I),
        .LANE_MASK_I    (LANE_MASK_I),
        .POL_I          (POL_I),
        .EI_DET_EN_I    (EI_DET_EN_I),
        .RTERM_TRIM_I   (RTERM_TRIM_I),
        .DI_I           (DI_I),
        .EI_DETECT_I    (EI_DETECT_I),
        .RTERM_EN_O     (RTERM_EN_O),
        .RX_VCM_EN_O    (RX_VCM_EN_O),
        .RX_EN_O        (RX_EN_O),
        .RX_POL_O       (RX_POL_O),
        .EI_DETECT_EN_O (EI_DETECT_EN_O),
        .RTERM_TRIM_O   (RTERM_TRIM_O),
        .DATA_O         (DATA_O),
        .EI_O           (EI_O),
        .LINK_IDLE_O    (LINK_IDLE_O),
        .READY_O        (READY_O),
        .STATE_O        (STATE_O)
    );

    always #5 CLK_I = ~CLK_I;

    task automatic tick;
        @(posedge CLK_I);
        #1;
    endtask

    task automatic step(input int n);
        repeat (n) tick();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        RSTN_I       = 1'b0;
        EN_I         = 1'b0;
        LANE_MASK_I  = 4'hF;
        POL_I        = 4'b0110;
        EI_DET_EN_I  = 1'b1;
        RTERM_TRIM_I = 4'h3;
        DI_I         = 4'h0;
        EI_DETECT_I  = 4'h0;

        // Reset state, held across clock edges
        #12;
        chk("rst_state", STATE_O, 0);
        chk("rst_ready", READY_O, 0);
        chk("rst_rterm", RTERM_EN_O, 0);
        chk("rst_pol", RX_POL_O, 0);
        chk("rst_trim", RTERM_TRIM_O, 0);
        RSTN_I = 1'b1;
        tick();
        chk("idle_state", STATE_O, 0);
        chk("pol_reg", RX_POL_O, 4'b0110);
        chk("trim_load_off", RTERM_TRIM_O, 4'h3);

        // Power-up: EN sampled at edge 0
        EN_I = 1'b1;
        tick();
        chk("pu_e0_state", STATE_O, 0);
        tick();
        chk("pu_e1_state", STATE_O, 1);
        chk("pu_e1_rterm", RTERM_EN_O, 4'hF);
        chk("pu_e1_vcm", RX_VCM_EN_O, 4'h0);
        step(3);
        chk("pu_e4_state", STATE_O, 1);
        tick();
        chk("pu_e5_state", STATE_O, 2);
        chk("pu_e5_vcm", RX_VCM_EN_O, 4'hF);
        chk("pu_e5_rx", RX_EN_O, 4'h0);
        step(3);
        chk("pu_e8_state", STATE_O, 2);
        tick();
        chk("pu_e9_state", STATE_O, 3);
        chk("pu_e9_rx", RX_EN_O, 4'hF);
        chk("pu_e9_ready", READY_O, 0);
        step(3);
        chk("pu_e12_ready", READY_O, 0);
        tick();
        chk("pu_e13_ready", READY_O, 1);
        chk("pu_e13_state", STATE_O, 4);
        chk("pu_e13_eien", EI_DETECT_EN_O, 4'hF);

        // Data path: two-edge latency
        DI_I = 4'b1010;
        tick();
        chk("data_lat1", DATA_O, 4'h0);
        tick();
        chk("data_lat2", DATA_O, 4'b1010);

        // EI glitch of 5 samples is rejected
        EI_DETECT_I = 4'b0100;
        step(5);
        EI_DETECT_I = 4'b0000;
        step(12);
        chk("ei_glitch", EI_O, 4'h0);

        // Stable EI high: toggles on 10th edge
        EI_DETECT_I = 4'b0100;
        step(9);
        chk("ei_rise_9", EI_O, 4'h0);
        tick();
        chk("ei_rise_10", EI_O, 4'b0100);
        chk("ei_rise_idle", LINK_IDLE_O, 0);
        EI_DETECT_I = 4'b0000;
        step(9);
        chk("ei_fall_9", EI_O, 4'b0100);
        tick();
        chk("ei_fall_10", EI_O, 4'h0);

        // Mask 0101: lanes 1 and 3 held off
        LANE_MASK_I = 4'b0101;
        DI_I        = 4'hF;
        tick();
        chk("mask_rterm", RTERM_EN_O, 4'b0101);
        chk("mask_vcm", RX_VCM_EN_O, 4'b0101);
        chk("mask_rx", RX_EN_O, 4'b0101);
        chk("mask_eien", EI_DETECT_EN_O, 4'b0101);
        tick();
        chk("mask_data", DATA_O, 4'b0101);
        EI_DETECT_I = 4'b1011;
        step(10);
        chk("mask_ei_l0", EI_O, 4'b0001);
        chk("mask_idle_0", LINK_IDLE_O, 0);
        EI_DETECT_I = 4'b1111;
        step(10);
        chk("mask_ei_l02", EI_O, 4'b0101);
        chk("mask_idle_1", LINK_IDLE_O, 1);
        LANE_MASK_I = 4'b0000;
        tick();
        chk("mask0_idle", LINK_IDLE_O, 0);
        chk("mask0_ei", EI_O, 4'h0);
        chk("mask0_rterm", RTERM_EN_O, 4'h0);
        chk("mask0_data", DATA_O, 4'h0);
        chk("mask0_ready", READY_O, 1);
        LANE_MASK_I = 4'hF;
        EI_DETECT_I = 4'h0;
        step(2);

        // Trim lock while live, reload once OFF
        RTERM_TRIM_I = 4'hA;
        step(3);
        chk("trim_hold", RTERM_TRIM_O, 4'h3);
        EN_I = 1'b0;
        tick();
        chk("off_k_state", STATE_O, 4);
        tick();
        chk("off_state", STATE_O, 0);
        chk("off_ready", READY_O, 0);
        chk("off_rterm", RTERM_EN_O, 4'h0);
        chk("off_data", DATA_O, 4'h0);
        chk("off_trim_hold", RTERM_TRIM_O, 4'h3);
        tick();
        chk("off_trim_load", RTERM_TRIM_O, 4'hA);

        // Abort during BIAS, then full restart
        EN_I = 1'b1;
        step(2);
        chk("ab_e1_state", STATE_O, 1);
        step(4);
        chk("ab_e5_state", STATE_O, 2);
        EN_I = 1'b0;
        tick();
        chk("ab_e6_state", STATE_O, 2);
        tick();
        chk("ab_e7_state", STATE_O, 0);
        chk("ab_e7_rterm", RTERM_EN_O, 4'h0);
        chk("ab_e7_vcm", RX_VCM_EN_O, 4'h0);
        EN_I = 1'b1;
        step(13);
        chk("ab_re_ready_early", READY_O, 0);
        tick();
        chk("ab_re_ready", READY_O, 1);

        // Async reset while in RXON
        EN_I = 1'b0;
        step(2);
        EN_I = 1'b1;
        step(10);
        chk("ar_rxon", STATE_O, 3);
        #3;
        RSTN_I = 1'b0;
        #1;
        chk("ar_state", STATE_O, 0);
        chk("ar_rx", RX_EN_O, 4'h0);
        chk("ar_rterm", RTERM_EN_O, 4'h0);
        chk("ar_pol", RX_POL_O, 4'h0);
        chk("ar_trim", RTERM_TRIM_O, 4'h0);
        RSTN_I = 1'b1;
        EN_I   = 1'b0;
        POL_I  = 4'b1001;
        tick();
        chk("ar_pol_new", RX_POL_O, 4'b1001);
        chk("ar_off", STATE_O, 0);
        step(3);
        chk("ar_off_stay", STATE_O, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

`default_nettype wire
